// File: rtl/pong_match_ctrl.sv
// -----------------------------------------------------------------------------
// pong_match_ctrl
//
// Match-level sequencer for the Pong game. It sits above the per-frame
// ball/paddle engine. It freezes the engine between points, launches each
// serve from the correct side and detects the end of the match. It also keeps
// the score, the rally length and the ball speed level.
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   frame_tick  in   one-cycle pulse, once per video frame
//   btn_start   in   start button level, already synchronised to clk
//   miss_l      in   one-cycle pulse: ball left the left edge (right scores)
//   miss_r      in   one-cycle pulse: ball left the right edge (left scores)
//   hit_pad     in   one-cycle pulse on any paddle bounce
//   state       out  FSM state: IDLE=0 SERVE_WAIT=1 PLAY=2 POINT=3 GAME_OVER=4
//   play_en     out  engine may move the ball (high only in PLAY)
//   serve_req   out  one-cycle pulse: place the ball at the serving paddle
//   serve_dir   out  0 = serve travels right, 1 = serve travels left
//   score_l/_r  out  player scores (never exceed WIN_SCORE)
//   rally_cnt   out  paddle hits in the current rally, saturating at 255
//   speed_lvl   out  ball speed level, saturating at 3
//   winner      out  00 none, 01 left player, 10 right player
//
// Signalling: this block has no valid/ready handshakes. Every event input is a
// single-cycle pulse that is sampled on the rising clock edge. It is consumed
// only in the state that listens for it and is silently dropped otherwise.
// There is no back-pressure. Every output is a register, so an event sampled
// at edge N is visible on the outputs just after edge N. serve_req is the only
// output pulse. It is high for exactly the first PLAY cycle.
// -----------------------------------------------------------------------------
module pong_match_ctrl #(
  parameter int WIN_SCORE    = 7,   // 1..15
  parameter int SERVE_FRAMES = 60,  // 1..255
  parameter int SPEEDUP      = 5    // 1..255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_start,
  input  logic       miss_l,
  input  logic       miss_r,
  input  logic       hit_pad,
  output logic [2:0] state,
  output logic       play_en,
  output logic       serve_req,
  output logic       serve_dir,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [7:0] rally_cnt,
  output logic [1:0] speed_lvl,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SERVE_WAIT = 3'd1,
    S_PLAY       = 3'd2,
    S_POINT      = 3'd3,
    S_GAME_OVER  = 3'd4
  } state_t;

  // The parameters are narrowed once to the register widths, so the compares
  // below are exact and width-matched.
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] HIT_LAST   = 8'(SPEEDUP - 1);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);

  state_t     state_q;
  logic       btn_start_q;  // resets to 1 so a button held through reset is not an edge
  logic [7:0] timer;        // frame ticks counted in SERVE_WAIT
  logic [7:0] hit_cnt;      // hits since the last speed increment
  logic       start_rise;

  assign start_rise = btn_start & ~btn_start_q;
  assign state      = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      btn_start_q <= 1'b1;
      timer       <= 8'd0;
      hit_cnt     <= 8'd0;
      play_en     <= 1'b0;
      serve_req   <= 1'b0;
      serve_dir   <= 1'b0;
      score_l     <= 4'd0;
      score_r     <= 4'd0;
      rally_cnt   <= 8'd0;
      speed_lvl   <= 2'd0;
      winner      <= 2'b00;
    end else begin
      btn_start_q <= btn_start;
      // serve_req is a pulse. It only stays high for the one cycle in which
      // SERVE_WAIT hands over to PLAY.
      serve_req   <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          score_l   <= 4'd0;
          score_r   <= 4'd0;
          winner    <= 2'b00;
          rally_cnt <= 8'd0;
          speed_lvl <= 2'd0;
          play_en   <= 1'b0;
          if (start_rise) begin
            serve_dir <= 1'b0;
            timer     <= 8'd0;
            state_q   <= S_SERVE_WAIT;
          end
        end

        S_SERVE_WAIT: begin
          if (frame_tick) begin
            if (timer == SERVE_LAST) begin
              timer     <= 8'd0;
              play_en   <= 1'b1;
              serve_req <= 1'b1;
              state_q   <= S_PLAY;
            end else begin
              timer <= timer + 8'd1;
            end
          end
        end

        S_PLAY: begin
          // A miss ends the rally. A paddle hit in the same cycle loses to it.
          if (miss_l && miss_r) begin
            // The ball cannot be at both edges at once. Replay the point
            // without crediting either side.
            play_en <= 1'b0;
            state_q <= S_POINT;
          end else if (miss_r) begin
            score_l   <= score_l + 4'd1;
            serve_dir <= 1'b1;
            play_en   <= 1'b0;
            state_q   <= S_POINT;
          end else if (miss_l) begin
            score_r   <= score_r + 4'd1;
            serve_dir <= 1'b0;
            play_en   <= 1'b0;
            state_q   <= S_POINT;
          end else if (hit_pad) begin
            if (rally_cnt != 8'hFF) begin
              rally_cnt <= rally_cnt + 8'd1;
            end
            if (hit_cnt == HIT_LAST) begin
              hit_cnt <= 8'd0;
              if (speed_lvl != 2'd3) begin
                speed_lvl <= speed_lvl + 2'd1;
              end
            end else begin
              hit_cnt <= hit_cnt + 8'd1;
            end
          end
        end

        S_POINT: begin
          rally_cnt <= 8'd0;
          speed_lvl <= 2'd0;
          hit_cnt   <= 8'd0;
          timer     <= 8'd0;
          if (score_l == WIN) begin
            winner  <= 2'b01;
            state_q <= S_GAME_OVER;
          end else if (score_r == WIN) begin
            winner  <= 2'b10;
            state_q <= S_GAME_OVER;
          end else begin
            state_q <= S_SERVE_WAIT;
          end
        end

        S_GAME_OVER: begin
          // Scores and winner stay on display until the next button press.
          if (start_rise) begin
            score_l <= 4'd0;
            score_r <= 4'd0;
            winner  <= 2'b00;
            state_q <= S_IDLE;
          end
        end

        default: begin
          play_en <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pong_match_ctrl
//
// The driver applies one input vector per clock on the falling edge. It steps
// a reference model of the match rules and queues the expected post-edge
// output vector. A separate monitor pops one entry just after each rising
// edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_pong_match_ctrl;

  localparam int WIN_SCORE    = 7;
  localparam int SERVE_FRAMES = 60;
  localparam int SPEEDUP      = 5;
  localparam int W            = 26;

  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_POINT = 3, M_OVER = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       frame_tick = 1'b0, btn_start = 1'b0;
  logic       miss_l = 1'b0, miss_r = 1'b0, hit_pad = 1'b0;
  logic [2:0] state;
  logic       play_en, serve_req, serve_dir;
  logic [3:0] score_l, score_r;
  logic [7:0] rally_cnt;
  logic [1:0] speed_lvl, winner;

  pong_match_ctrl #(
    .WIN_SCORE(WIN_SCORE), .SERVE_FRAMES(SERVE_FRAMES), .SPEEDUP(SPEEDUP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .btn_start(btn_start),
    .miss_l(miss_l), .miss_r(miss_r), .hit_pad(hit_pad),
    .state(state), .play_en(play_en), .serve_req(serve_req),
    .serve_dir(serve_dir), .score_l(score_l), .score_r(score_r),
    .rally_cnt(rally_cnt), .speed_lvl(speed_lvl), .winner(winner)
  );

  // ---------------- reference model ----------------
  // Match rules written in plain integer arithmetic. Each call to m_step
  // covers one clock edge.
  int m_mode, m_frames, m_hits, m_sl, m_sr, m_rally, m_speed, m_win;
  bit m_dir, m_serve, m_btn_prev;

  function automatic void m_reset();
    m_mode = M_IDLE; m_frames = 0; m_hits = 0; m_sl = 0; m_sr = 0;
    m_rally = 0; m_speed = 0; m_win = 0; m_dir = 0; m_serve = 0;
    m_btn_prev = 1;
  endfunction

  function automatic void m_step(bit r, bit t, bit b, bit ml, bit mr, bit h);
    bit press;
    if (!r) begin
      m_reset();
      return;
    end
    press      = b && !m_btn_prev;
    m_btn_prev = b;
    m_serve    = 0;
    case (m_mode)
      M_IDLE: begin
        m_sl = 0; m_sr = 0; m_win = 0; m_rally = 0; m_speed = 0;
        if (press) begin m_dir = 0; m_frames = 0; m_mode = M_SERVE; end
      end
      M_SERVE: if (t) begin
        m_frames++;
        if (m_frames == SERVE_FRAMES) begin
          m_frames = 0; m_serve = 1; m_mode = M_PLAY;
        end
      end
      M_PLAY: begin
        if (ml && mr) m_mode = M_POINT;
        else if (mr) begin m_sl++; m_dir = 1; m_mode = M_POINT; end
        else if (ml) begin m_sr++; m_dir = 0; m_mode = M_POINT; end
        else if (h) begin
          m_rally = (m_rally >= 255) ? 255 : m_rally + 1;
          m_hits++;
          if (m_hits == SPEEDUP) begin
            m_hits = 0;
            m_speed = (m_speed >= 3) ? 3 : m_speed + 1;
          end
        end
      end
      M_POINT: begin
        m_rally = 0; m_speed = 0; m_hits = 0; m_frames = 0;
        if (m_sl == WIN_SCORE)      begin m_win = 1; m_mode = M_OVER; end
        else if (m_sr == WIN_SCORE) begin m_win = 2; m_mode = M_OVER; end
        else m_mode = M_SERVE;
      end
      default: if (press) begin  // M_OVER
        m_sl = 0; m_sr = 0; m_win = 0; m_mode = M_IDLE;
      end
    endcase
  endfunction

  function automatic logic [W-1:0] m_pack();
    return {3'(m_mode), (m_mode == M_PLAY), m_serve, m_dir, 4'(m_sl), 4'(m_sr),
            8'(m_rally), 2'(m_speed), 2'(m_win)};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  bit btn_lvl = 0;

  // Monitor: compares one queued expectation after every rising edge.
  initial begin
    logic [W-1:0] exp_v, act_v;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {state, play_en, serve_req, serve_dir, score_l, score_r,
                 rally_cnt, speed_lvl, winner};
        vectors++;
        if (act_v !== exp_v) begin
          miscompares++;
          $display("FAIL outputs @%0t: actual st=%0d pe=%0b sq=%0b dir=%0b sl=%0d sr=%0d rally=%0d spd=%0d win=%0d, required st=%0d pe=%0b sq=%0b dir=%0b sl=%0d sr=%0d rally=%0d spd=%0d win=%0d",
                   $time, act_v[25:23], act_v[22], act_v[21], act_v[20], act_v[19:16],
                   act_v[15:12], act_v[11:4], act_v[3:2], act_v[1:0],
                   exp_v[25:23], exp_v[22], exp_v[21], exp_v[20], exp_v[19:16],
                   exp_v[15:12], exp_v[11:4], exp_v[3:2], exp_v[1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit r, input bit t, input bit ml, input bit mr, input bit h);
    @(negedge clk);
    rst_n = r; frame_tick = t; btn_start = btn_lvl;
    miss_l = ml; miss_r = mr; hit_pad = h;
    m_step(r, t, btn_lvl, ml, mr, h);
    exp_q.push_back(m_pack());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
  endtask

  task automatic press_start();
    btn_lvl = 0; cyc(1, 0, 0, 0, 0);
    btn_lvl = 1; cyc(1, 0, 0, 0, 0);
    btn_lvl = 0; cyc(1, 0, 0, 0, 0);
  endtask

  // Frame ticks with random gaps. The gaps carry hit/miss noise, which must be
  // ignored while the controller waits to serve.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++)
        cyc(1, 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1);
      cyc(1, 1, 0, 0, $urandom_range(0, 1) == 1);
    end
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1, $urandom_range(0, 1) == 1, 0, 0, 1);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
  endtask

  task automatic miss(input bit ml, input bit mr);
    cyc(1, 0, ml, mr, $urandom_range(0, 1) == 1);
    idle(2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_reset();
    // Reset with random inputs.
    for (int i = 0; i < 5; i++) begin
      btn_lvl = $urandom_range(0, 1) == 1;
      cyc(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end
    // Release with the button held: no start until it is released and pressed.
    btn_lvl = 1;
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
    idle(4);
    press_start();

    // Serve, then a long rally to saturate rally_cnt and speed_lvl.
    ticks(SERVE_FRAMES);
    idle(2);
    hits(300);
    miss(0, 1);          // left scores, serve goes left
    ticks(SERVE_FRAMES);
    hits(20);
    miss(1, 0);          // right scores, serve goes right
    ticks(SERVE_FRAMES);
    hits(7);
    miss(1, 1);          // simultaneous misses: no score change
    // Reset in the middle of SERVE_WAIT.
    ticks(30);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    idle(3);
    hits(4);             // hit_pad in IDLE is ignored

    // Full match won by the left player.
    press_start();
    for (int p = 0; p < WIN_SCORE; p++) begin
      ticks(SERVE_FRAMES);
      hits(int'($urandom_range(0, 8)));
      miss(0, 1);
    end
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 1);  // ignored after match end
    idle(2);
    press_start();
    idle(3);

    // Random traffic.
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 39) == 0) btn_lvl = ~btn_lvl;
      cyc($urandom_range(0, 1499) != 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0,
          $urandom_range(0, 3) == 0);
    end

    // Drain the queue within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: actual %0d entries left, required 0", exp_q.size());
    end

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
